serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Serial frame receiver consuming the one-bit-per-clock stream produced by the team's serial delay/shift stage. Detects a start bit, deserializes DATA_W data bits LSB first, checks an optional even-parity bit and the stop bit, and presents each good word on a one-entry output register with valid/ready handshake. Sits directly downstream of the serial shift stage and upstream of the parallel datapath.

## Interface
- DATA_W, 8, data bits per frame (2..16)
- PARITY_EN, 1, 1 = frame carries even-parity bit after data; 0 = no parity bit
- clk  input  1  clock; all sampling on posedge
- reset  input  1  asynchronous, active-high reset
- in  input  1  serial line; idle level 1
- out_data  output  DATA_W  received word, valid while out_valid=1
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts word when out_valid & out_ready
- parity_err  output  1  one-cycle pulse: parity mismatch, frame dropped
- frame_err  output  1  one-cycle pulse: stop bit was 0, frame dropped
- overrun  output  1  one-cycle pulse: good frame dropped because holding register full

## Operation
- One clock decides the reset; the async, active-high reset forces state IDLE, the shift register to 0, out_data=0, out_valid=0, parity_err=0, frame_err=0, overrun=0.
- Frame on the line: start(0), DATA_W data bits LSB first, parity (if PARITY_EN), stop(1). One bit per clock, no oversampling.
- States: IDLE, DATA, PARITY, STOP, BREAK.
  - IDLE: in=0 -> DATA, bit counter cleared, parity accumulator cleared. in=1 -> stay.
  - DATA: shift in into MSB side (right shift), XOR into parity accumulator, count; after DATA_W-th bit -> PARITY if PARITY_EN else STOP.
  - PARITY: compare in with accumulator (even: data-ones + parity bit even) -> STOP; latch mismatch.
  - STOP: in=1 -> IDLE; in=0 -> BREAK.
  - BREAK: wait for in=1 -> IDLE. A low line never retriggers a start from BREAK.
- Frame completion (in STOP):
  - stop=0: frame_err pulse; word dropped; parity_err also pulses if parity mismatched.
  - stop=1, parity mismatch: parity_err pulse; word dropped.
  - stop=1, parity ok: if out_valid=0, or out_ready=1 in the same cycle, load out_data and set out_valid; else overrun pulse, word dropped, held word unchanged.
- out_valid clears on out_valid & out_ready when no new load occurs that cycle. out_data stable while out_valid=1 and not consumed.
- Receiver never stalls the line; holding register is the only buffering.

## Timing
- Start bit sampled in IDLE at cycle t. Data bits at t+1..t+DATA_W. Parity at t+DATA_W+1 (if enabled). Stop at t+DATA_W+1+PARITY_EN.
- out_valid / error pulses visible at t+DATA_W+2+PARITY_EN (registered; DATA_W=8, parity on: t+11).
- Back-to-back: next start may be sampled on the cycle after the stop bit (frame period DATA_W+2+PARITY_EN cycles, no idle bit required).
- Reset asserted mid-frame: partial frame discarded, no error pulse, held word lost.
- Error and overrun outputs are pulses of exactly one cycle; never asserted outside completion cycle.

## Structure
- Package serial_frame_pkg: state enum (IDLE, DATA, PARITY, STOP, BREAK), constants LINE_IDLE=1, START_LVL=0, STOP_LVL=1, bit-counter width function clog2(DATA_W+1).
- One sub-module natural: sfr_shift_in (DATA_W-bit right-shift register with shift enable, clear, and running XOR parity output). FSM, completion logic and output register stay in top.

## Test plan
- DATA_W=8, PARITY_EN=1, reset then frame 0xA5 (bits 1,0,1,0,0,1,0,1, parity 0, stop 1), out_ready=1 -> out_data=0xA5, out_valid high exactly at t+11 for one cycle, no error pulses.
- Frame 0x3C with parity bit 1 (wrong) -> parity_err pulse at t+11, out_valid stays 0.
- Frame 0x0F with stop bit 0, line held 0 for 5 more cycles then 1 -> frame_err pulse at t+11, no new frame decoded until line returns to 1.
- out_ready=0, frames 0x11 then 0x22 back-to-back -> out_data=0x11 held, overrun pulse at second completion; raise out_ready -> 0x11 consumed, out_valid drops.
- out_valid=1 with out_ready=1 on the same cycle 0x55 completes -> 0x55 replaces held word, no overrun, out_valid stays 1.
- Assert reset at t+5 of frame 0x99 -> all outputs 0 asynchronously; after release, idle line, then frame 0x42 received correctly.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// The state enum, line levels and bit-counter sizing helper live here.
package serial_frame_pkg;

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial line in, parallel word out with valid/ready, plus error pulses.
// The receiver uses the master modport; the consumer/line driver uses slave.
interface serial_frame_rx_if #(parameter int DATA_W = 8);
  logic              in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (
    input  in, out_ready,
    output out_data, out_valid, parity_err, frame_err, overrun
  );

  modport slave (
    output in, out_ready,
    input  out_data, out_valid, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/sfr_shift_in.sv
// LSB-first deserializer: right-shift register with a running XOR of every bit
// shifted in, so the parity of the received data is ready when the word is.
module sfr_shift_in #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data,
  output logic              parity
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      data   <= '0;
      parity <= 1'b0;
    end else if (shift_en) begin
      data   <= {bit_in, data[DATA_W-1:1]};
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even
// parity, stop bit; good words land in a one-entry valid/ready holding register.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  serial_frame_rx_if.master bus
);

  localparam int CNT_W = clog2(DATA_W + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic               par_bad;
  logic               shift_en, clear, complete, load, last_bit;
  logic [DATA_W-1:0]  shift_data;
  logic               shift_par;

  sfr_shift_in #(.DATA_W(DATA_W)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .shift_en (shift_en),
    .bit_in   (bus.in),
    .data     (shift_data),
    .parity   (shift_par)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    clear      = 1'b0;
    complete   = 1'b0;
    last_bit   = (bit_cnt == CNT_W'(DATA_W - 1));
    case (state)
      IDLE:   if (bus.in == START_LVL) begin
                state_next = DATA;
                clear      = 1'b1;
              end
      DATA:   begin
                shift_en = 1'b1;
                if (last_bit) state_next = PARITY_EN ? PARITY : STOP;
              end
      PARITY: state_next = STOP;
      STOP:   begin
                complete   = 1'b1;
                state_next = (bus.in == STOP_LVL) ? IDLE : BREAK;
              end
      // A held-low line after a bad stop must not look like a new start bit.
      BREAK:  if (bus.in == LINE_IDLE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    load = complete && (bus.in == STOP_LVL) && !par_bad &&
           (!bus.out_valid || bus.out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      par_bad <= 1'b0;
    end else begin
      if (clear)         bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + CNT_W'(1);
      if (clear)                 par_bad <= 1'b0;
      else if (state == PARITY)  par_bad <= bus.in ^ shift_par;
    end
  end

  // Pulses are registered so they appear exactly one cycle after the stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_data   <= '0;
      bus.out_valid  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.parity_err <= complete && par_bad;
      bus.frame_err  <= complete && (bus.in != STOP_LVL);
      bus.overrun    <= complete && (bus.in == STOP_LVL) && !par_bad &&
                        bus.out_valid && !bus.out_ready;
      if (load) begin
        bus.out_data  <= shift_data;
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (DATA_W=8, even parity enabled):
// directed scenarios plus randomized frames against a word-level reference model.
module tb_serial_frame_rx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_frame_rx_if #(.DATA_W(8)) bus();

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: holding register and pulses, updated per frame verdict.
  logic       m_valid, m_perr, m_ferr, m_ovr;
  logic [7:0] m_data;

  typedef struct {
    logic       b;
    logic       comp;
    logic       pbad;
    logic       sbad;
    logic [7:0] d;
  } ev_t;

  function automatic logic [11:0] obs();
    return {bus.out_valid, bus.out_data, bus.parity_err, bus.frame_err, bus.overrun};
  endfunction

  function automatic logic [11:0] expv();
    return {m_valid, m_data, m_perr, m_ferr, m_ovr};
  endfunction

  function automatic logic [3:0] flags();
    return {bus.out_valid, bus.parity_err, bus.frame_err, bus.overrun};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00;
    m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  // One line bit per clock; comp marks the cycle whose bit is the stop bit.
  task automatic step(input logic b, input logic rdy, input logic comp,
                      input logic pbad, input logic sbad, input logic [7:0] word);
    logic good;
    @(negedge clk);
    bus.in        = b;
    bus.out_ready = rdy;
    @(posedge clk);
    good   = comp && !pbad && !sbad;
    m_perr = comp && pbad;
    m_ferr = comp && sbad;
    m_ovr  = 1'b0;
    if (good && (!m_valid || rdy)) begin
      m_valid = 1'b1;
      m_data  = word;
    end else begin
      if (good) m_ovr = 1'b1;
      if (m_valid && rdy) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic send_bits(input logic [7:0] d, input logic p, input logic s,
                           input int lo, input int hi, input logic rdy);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int k = lo; k <= hi; k++) step(f[k], rdy, k == 10, p != ^d, !s, d);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_held: got %h, expected %h", obs(), 12'h000);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (obs() !== 12'h000) begin
        errors++;
        $display("[TB] FAIL reset_idle: got %h, expected %h", obs(), 12'h000);
      end
    end
  endtask

  task automatic test_good_frame();
    send_bits(8'hA5, 1'b0, 1'b1, 0, 9, 1'b1);
    checks++;
    if (flags() !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL good_early: got %b, expected %b", flags(), 4'b0000);
    end
    send_bits(8'hA5, 1'b0, 1'b1, 10, 10, 1'b1);
    checks++;
    if (obs() !== {1'b1, 8'hA5, 3'b000}) begin
      errors++;
      $display("[TB] FAIL good_done: got %h, expected %h", obs(), {1'b1, 8'hA5, 3'b000});
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (flags() !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL good_consumed: got %b, expected %b", flags(), 4'b0000);
    end
  endtask

  task automatic test_parity_err();
    send_bits(8'h3C, 1'b1, 1'b1, 0, 10, 1'b1);
    checks++;
    if (flags() !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL parity_pulse: got %b, expected %b", flags(), 4'b0100);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (flags() !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL parity_one_cycle: got %b, expected %b", flags(), 4'b0000);
    end
  endtask

  task automatic test_frame_err();
    send_bits(8'h0F, 1'b0, 1'b0, 0, 10, 1'b1);
    checks++;
    if (flags() !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL frame_pulse: got %b, expected %b", flags(), 4'b0010);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (flags() !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL frame_low_hold: got %b, expected %b", flags(), 4'b0000);
    end
    // A retriggered start inside the low stretch would complete within 12 cycles.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (flags() !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL break_no_retrigger cyc %0d: got %b, expected %b", i, flags(), 4'b0000);
      end
    end
  endtask

  task automatic test_overrun();
    send_bits(8'h11, 1'b0, 1'b1, 0, 10, 1'b0);
    checks++;
    if (obs() !== {1'b1, 8'h11, 3'b000}) begin
      errors++;
      $display("[TB] FAIL ovr_first: got %h, expected %h", obs(), {1'b1, 8'h11, 3'b000});
    end
    send_bits(8'h22, 1'b0, 1'b1, 0, 10, 1'b0);
    checks++;
    if (obs() !== {1'b1, 8'h11, 3'b001}) begin
      errors++;
      $display("[TB] FAIL ovr_pulse: got %h, expected %h", obs(), {1'b1, 8'h11, 3'b001});
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (flags() !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL ovr_drain: got %b, expected %b", flags(), 4'b0000);
    end
  endtask

  task automatic test_back_to_back_replace();
    send_bits(8'h33, 1'b0, 1'b1, 0, 10, 1'b0);
    send_bits(8'h55, 1'b0, 1'b1, 0, 9, 1'b0);
    checks++;
    if (obs() !== {1'b1, 8'h33, 3'b000}) begin
      errors++;
      $display("[TB] FAIL replace_held: got %h, expected %h", obs(), {1'b1, 8'h33, 3'b000});
    end
    send_bits(8'h55, 1'b0, 1'b1, 10, 10, 1'b1);
    checks++;
    if (obs() !== {1'b1, 8'h55, 3'b000}) begin
      errors++;
      $display("[TB] FAIL replace_load: got %h, expected %h", obs(), {1'b1, 8'h55, 3'b000});
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_frame();
    send_bits(8'h77, 1'b1, 1'b1, 0, 10, 1'b0);
    send_bits(8'h99, 1'b0, 1'b1, 0, 5, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs() !== 12'h000) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h, expected %h", obs(), 12'h000);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (obs() !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_discard: got %h, expected %h", obs(), 12'h000);
    end
    send_bits(8'h42, 1'b0, 1'b1, 0, 10, 1'b1);
    checks++;
    if (obs() !== {1'b1, 8'h42, 3'b000}) begin
      errors++;
      $display("[TB] FAIL after_reset: got %h, expected %h", obs(), {1'b1, 8'h42, 3'b000});
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    ev_t         q[$];
    ev_t         e;
    logic [7:0]  d;
    logic        p, s;
    logic [10:0] f;
    for (int n = 0; n < 80; n++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? !(^d) : ^d;
      s = ($urandom_range(0, 4) != 0);
      f = {s, p, d, 1'b0};
      for (int k = 0; k <= 10; k++) begin
        e.b = f[k]; e.comp = (k == 10); e.pbad = (p != ^d); e.sbad = !s; e.d = d;
        q.push_back(e);
      end
      e.comp = 1'b0; e.pbad = 1'b0; e.sbad = 1'b0; e.d = 8'h00;
      if (!s) begin
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
          e.b = 1'b0; q.push_back(e);
        end
        e.b = 1'b1; q.push_back(e);
      end else begin
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
          e.b = 1'b1; q.push_back(e);
        end
      end
    end
    foreach (q[i]) begin
      step(q[i].b, 1'($urandom_range(0, 1)), q[i].comp, q[i].pbad, q[i].sbad, q[i].d);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("[TB] FAIL random step %0d: got %h, expected %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    bus.in        = 1'b1;
    bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_back_to_back_replace();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
